// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
//   MM:SS board timer. Four BCD digits count down (timer) or up (stopwatch)
//   once per prescaler tick. Adds start/stop control, a direction and an
//   auto-reload mode latched at start, a one-cycle done pulse with a held
//   alarm, and BCD validation of the preset on load.
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   reset      synchronous reset, active low, dominates every other input
//   load       pulse: load preset digits (ignored while running)
//   start      pulse: begin / resume counting
//   stop       pulse: pause counting (beats start in the same cycle)
//   up_dn      1 = count up, 0 = count down (latched on start)
//   reload_en  1 = wrap / reload at terminal count (latched on start)
//   min10_in, min1_in, sec10_in, sec1_in   BCD preset digits
//   digits     {min10, min1, sec10, sec1}, always valid BCD
//   running    high while counting
//   alarm      high while parked at the terminal count
//   done       one-cycle pulse on the terminal tick
//   error      sticky flag: last load attempt carried an invalid preset
// ---------------------------------------------------------------------------

// One BCD digit of the count chain. The digit steps only when i_en is set
// (the lower digit wrapped, or this is the lowest digit). o_carry marks a
// wrap: MAX->0 going up, 0->MAX going down, and enables the next digit.
module bcd_digit_step #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic [3:0] i_digit,
  input  logic       i_en,
  input  logic       i_up,
  output logic [3:0] o_digit,
  output logic       o_carry
);

  always_comb begin
    o_digit = i_digit;
    o_carry = 1'b0;
    if (i_en) begin
      if (i_up) begin
        if (i_digit >= MAX) begin
          o_digit = 4'd0;
          o_carry = 1'b1;
        end else begin
          o_digit = i_digit + 4'd1;
        end
      end else begin
        if (i_digit == 4'd0) begin
          o_digit = MAX;
          o_carry = 1'b1;
        end else begin
          o_digit = i_digit - 4'd1;
        end
      end
    end
  end

endmodule

module bcd_countdown_timer #(
  parameter int CLK_DIV = 100000000,
  parameter int DIV_W   = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        start,
  input  logic        stop,
  input  logic        up_dn,
  input  logic        reload_en,
  input  logic [3:0]  min10_in,
  input  logic [3:0]  min1_in,
  input  logic [3:0]  sec10_in,
  input  logic [3:0]  sec1_in,
  output logic [15:0] digits,
  output logic        running,
  output logic        alarm,
  output logic        done,
  output logic        error
);

  localparam int NUM_DIG = 4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Digit index 0 is sec1, 3 is min10, so the packed array flattens
  // straight into the {min10,min1,sec10,sec1} output order.
  state_t                       r_state, w_state_nxt;
  logic [DIV_W-1:0]             r_presc, w_presc_nxt;
  logic [NUM_DIG-1:0][3:0]      r_dig, w_dig_nxt;
  logic [NUM_DIG-1:0][3:0]      r_reload, w_reload_nxt;
  logic                         r_up, w_up_nxt;
  logic                         r_rld, w_rld_nxt;
  logic                         r_done, w_done_nxt;
  logic                         r_err, w_err_nxt;
  logic                         r_running, r_alarm;

  logic [NUM_DIG-1:0][3:0]      w_preset;
  logic                         w_preset_ok;
  logic                         w_is_zero;
  logic [NUM_DIG-1:0][3:0]      w_step;
  logic [NUM_DIG:0]             w_carry;
  logic [NUM_DIG-1:0][3:0]      w_tick_dig;
  logic                         w_term;
  logic                         w_to_done;

  assign w_preset    = {min10_in, min1_in, sec10_in, sec1_in};
  assign w_preset_ok = (min10_in <= 4'd9) && (min1_in <= 4'd9) &&
                       (sec10_in <= 4'd5) && (sec1_in <= 4'd9);
  assign w_is_zero   = (r_dig == '0);

  // ---------------------------------------------------------------------
  // Ripple-carry BCD chain, direction from the mode latched at start.
  // ---------------------------------------------------------------------
  assign w_carry[0] = 1'b1;

  generate
    for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
      // sec10 is the only base-6 digit
      localparam logic [3:0] DMAX = (g == 1) ? 4'd5 : 4'd9;
      bcd_digit_step #(.MAX(DMAX)) u_step (
        .i_digit (r_dig[g]),
        .i_en    (w_carry[g]),
        .i_up    (r_up),
        .o_digit (w_step[g]),
        .o_carry (w_carry[g+1])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Value the digits take on a tick, and whether that tick is terminal.
  // A carry out of the top digit means the chain sat at its boundary:
  // 99:59 going up, 00:00 going down.
  // ---------------------------------------------------------------------
  always_comb begin
    w_tick_dig = w_step;
    w_term     = 1'b0;
    if (r_up) begin
      if (w_carry[NUM_DIG]) begin
        w_term     = 1'b1;
        // without reload the count saturates at 99:59
        w_tick_dig = r_rld ? '0 : r_dig;
      end
    end else begin
      // Down mode: sitting at 00:00 in RUN only happens after a reload
      // terminal tick, so the next tick restarts from the reload copy.
      if (w_carry[NUM_DIG])
        w_tick_dig = r_rld ? r_reload : '0;
      w_term = (w_tick_dig == '0);
    end
    // A zero reload copy in down mode has nothing to reload, so park.
    w_to_done = w_term && (!r_rld || (!r_up && (r_reload == '0)));
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_presc_nxt  = r_presc;
    w_dig_nxt    = r_dig;
    w_reload_nxt = r_reload;
    w_up_nxt     = r_up;
    w_rld_nxt    = r_rld;
    w_done_nxt   = 1'b0;
    w_err_nxt    = r_err;

    case (r_state)
      S_RUN: begin
        // load and start are meaningless here; stop outranks a tick
        if (stop) begin
          w_state_nxt = S_PAUSE;
        end else if (r_presc == DIV_LAST) begin
          w_presc_nxt = '0;
          w_dig_nxt   = w_tick_dig;
          w_done_nxt  = w_term;
          if (w_to_done)
            w_state_nxt = S_DONE;
        end else begin
          w_presc_nxt = r_presc + DIV_W'(1);
        end
      end

      default: begin
        // IDLE, PAUSE and DONE: load outranks start
        if (load) begin
          if (w_preset_ok) begin
            w_dig_nxt    = w_preset;
            w_reload_nxt = w_preset;
            w_err_nxt    = 1'b0;
            w_presc_nxt  = '0;
            w_state_nxt  = S_IDLE;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (start && (r_state != S_DONE) && !(!up_dn && w_is_zero)) begin
          w_up_nxt    = up_dn;
          w_rld_nxt   = reload_en;
          w_state_nxt = S_RUN;
          // a resume from PAUSE keeps the partial prescaler count
          if (r_state == S_IDLE)
            w_presc_nxt = '0;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_dig     <= '0;
      r_reload  <= '0;
      r_up      <= 1'b0;
      r_rld     <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_dig     <= w_dig_nxt;
      r_reload  <= w_reload_nxt;
      r_up      <= w_up_nxt;
      r_rld     <= w_rld_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      // decoded from the next state so they line up with r_state
      r_running <= (w_state_nxt == S_RUN);
      r_alarm   <= (w_state_nxt == S_DONE);
    end
  end

  assign digits  = r_dig;
  assign running = r_running;
  assign alarm   = r_alarm;
  assign done    = r_done;
  assign error   = r_err;

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised successor to the MM:SS board timer.
- Holds four BCD digits (min10, min1, sec10, sec1) and counts them down or up once per internal tick.
- The tick comes from an integrated prescaler driven by the system clock.
- Adds: explicit start/stop control, latched direction mode, optional auto-reload, a done pulse with a held alarm, and BCD validation on load. Outputs feed the existing seven-segment display driver and the board LEDs.

Parameters:
- CLK_DIV, 100000000, system clock cycles per count tick; must be >= 2. Bench uses 4.
- DIV_W, 27, prescaler counter width; must satisfy 2^DIV_W >= CLK_DIV.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset.
- load  input  1  one-cycle pulse; load the preset digits.
- start  input  1  one-cycle pulse; begin or resume counting.
- stop  input  1  one-cycle pulse; pause counting.
- up_dn  input  1  1 = count up (stopwatch), 0 = count down; sampled on start.
- reload_en  input  1  1 = auto-reload/wrap at terminal count; sampled on start.
- min10_in, min1_in, sec10_in, sec1_in  input  4 each  BCD preset digits.
- digits  output  16  current time, {min10,min1,sec10,sec1}, BCD.
- running  output  1  high while in RUN.
- alarm  output  1  high while in DONE.
- done  output  1  one-cycle pulse on reaching terminal count.
- error  output  1  sticky flag for an invalid preset.

Behaviour:
Reset:
- reset low at a rising clk edge sets: digits=0, reload copy=0, prescaler=0, state=IDLE, running=0, alarm=0, done=0, error=0, latched mode=down, latched reload_en=0.
- Reset has priority over every other input.

States:
- IDLE: start -> RUN.
- RUN: stop -> PAUSE; terminal tick -> DONE (if reload disabled).
- PAUSE: start -> RUN.
- DONE: leave only via load -> IDLE.

Load (accepted in IDLE, PAUSE and DONE; ignored in RUN):
- Invalid preset = min10_in>9, min1_in>9, sec10_in>5 or sec1_in>9.
- Invalid preset: error=1; digits, reload copy and state are unchanged.
- Valid preset: digits and reload copy take the inputs, error=0, prescaler=0, state=IDLE.
- If load and start arrive in the same cycle, load wins and start is dropped.

Start:
- In IDLE or PAUSE: latch up_dn and reload_en, then go to RUN.
- Down mode with digits=00:00: start is ignored; state stays put.
- Start in RUN or DONE is ignored.
- On IDLE->RUN the prescaler clears. On PAUSE->RUN it resumes from its held value.

Stop:
- In RUN: go to PAUSE; prescaler and digits are held.
- Elsewhere: ignored.
- If start and stop arrive in the same cycle in RUN, stop wins.

Prescaler (RUN only):
- Counts 0..CLK_DIV-1.
- A tick occurs on the edge where prescaler==CLK_DIV-1; prescaler returns to 0 on that edge.
- Digits update on the same edge. First update is exactly CLK_DIV cycles after the start edge (from IDLE).
- A stop in the tick cycle takes priority: no update happens.

Down count:
- sec1 decrements 9..0; at 0 it borrows and goes to 9.
- sec10 goes 5..0, then borrows and goes to 5.
- min1 goes 9..0, then borrows.
- min10 decrements.

Up count:
- sec1 0..9, carry; sec10 0..5, carry; min1 0..9, carry; min10 0..9.

Terminal tick (digits become 00:00 when counting down, or the tick occurs at 99:59 when counting up):
- done=1 for exactly that one cycle.
- If latched reload is 0:
  - Down mode: digits stay 00:00 and state goes to DONE.
  - Up mode: digits saturate at 99:59 and state goes to DONE.
- If latched reload is 1:
  - Down mode: after showing 00:00 for that tick, the next tick loads the reload copy instead of decrementing. State stays RUN.
  - Up mode: digits wrap to 00:00 on the terminal tick. State stays RUN.
  - A reload copy of 00:00 in down mode goes to DONE instead.

Output timing and invariants:
- running and alarm are registered decodes of the state. done is registered.
- Inputs change only mode behaviour at start; up_dn and reload_en toggling during RUN have no effect.
- digits is always valid BCD with sec10<=5.

Test Plan:
- Reset and load: reset=0 for 2 cycles -> all outputs 0. Load 01:05 -> digits=16'h0105, error=0, state IDLE.
- Invalid load: digits=16'h0105; load sec10_in=6 -> error=1, digits still 16'h0105. Load 00:02 -> error=0.
- Down count, CLK_DIV=4, no reload: load 00:02, start. Digits=16'h0001 at start+4 cycles, 16'h0000 at start+8 with done=1 for 1 cycle. Then alarm=1, running=0. A later start is ignored. Load returns to IDLE with alarm=0.
- Borrow chain and pause: load 10:00, start. First tick -> 16'h0959. Stop after 2 ticks -> digits hold 16'h0958 for 20 cycles. Start -> next tick after the remaining prescaler count -> 16'h0957.
- Auto-reload: load 00:01, reload_en=1, start. Tick1 -> 16'h0000 with done pulse, running stays 1. Tick2 -> 16'h0001. Tick3 -> 0000 with done pulse again.
- Up mode saturation and wrap plus mid-run reset: load 99:58, up_dn=1, reload_en=0, start. Tick1 -> 16'h9959. Tick2 -> done pulse, digits stay 9959, alarm=1. Repeat with reload_en=1 -> 16'h0000, running=1. Assert reset mid-RUN -> next edge all outputs 0, state IDLE.
